// File: rtl/attopu_pkg.sv
// Shared attopu definitions: word width, next-PC select codes and
// fetch-unit state encodings (also used by the decoder).
package attopu_pkg;

    localparam int WORD_W = 16;

    localparam logic [1:0] NPC_INC = 2'b00;
    localparam logic [1:0] NPC_REL = 2'b01;
    localparam logic [1:0] NPC_REG = 2'b10;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_FETCH = 2'd1,
        FS_ISSUE = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_next.sv
// Combinational next-PC selection for the fetch unit: increment,
// PC-relative branch, or register-indirect target.
module fetch_pc_next
    import attopu_pkg::*;
(
    input  logic [WORD_W-1:0] pc,
    input  logic [1:0]        sel,
    input  logic [WORD_W-1:0] branch_addr,
    input  logic [WORD_W-1:0] branch_reg,
    output logic [WORD_W-1:0] next_pc
);

    logic signed [WORD_W-1:0] offset;

    // branch_addr arrives sign-extended; a two's-complement add that wraps
    // at 2^16 gives the correct relative target for negative offsets too.
    assign offset = branch_addr;

    always_comb begin
        next_pc = pc + 16'd1;
        if (sel[1]) begin
            next_pc = branch_reg;
        end else if (sel == NPC_REL) begin
            next_pc = pc + offset;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// attopu instruction-fetch stage: owns the PC, fetches over req/ack and
// holds the instruction for the decoder. Optional ATTOPU_FETCH_PERF_EN
// adds handshake and fetch-wait performance counters.
module fetch_unit
    import attopu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic [WORD_W-1:0] instruction,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic [1:0]        next_pc_sel,
    input  logic [WORD_W-1:0] branch_addr,
    input  logic [WORD_W-1:0] branch_reg,
`ifdef ATTOPU_FETCH_PERF_EN
    output logic [31:0]       perf_instr_cnt,
    output logic [31:0]       perf_wait_cnt,
`endif
    output logic [WORD_W-1:0] pc
);

    fetch_state_e      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] instr_q, instr_d;
    logic              valid_q, valid_d;
    logic [WORD_W-1:0] next_pc;
    logic              consume;

    fetch_pc_next u_pc_next (
        .pc          (pc_q),
        .sel         (next_pc_sel),
        .branch_addr (branch_addr),
        .branch_reg  (branch_reg),
        .next_pc     (next_pc)
    );

    assign consume = valid_q & instr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FS_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        case (state_q)
            FS_IDLE: begin
                if (run) begin
                    state_d = FS_FETCH;
                end
            end
            FS_FETCH: begin
                // run is deliberately ignored here: an issued fetch always completes.
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    state_d = FS_ISSUE;
                end
            end
            FS_ISSUE: begin
                if (consume) begin
                    pc_d    = next_pc;
                    valid_d = 1'b0;
                    state_d = run ? FS_FETCH : FS_IDLE;
                end
            end
            default: begin
                state_d = FS_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // Request decodes from registered state only, so reset drops it at once
    // and no ack/rdata path reaches any output.
    assign imem_req    = (state_q == FS_FETCH);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instruction = instr_q;
    assign instr_valid = valid_q;

`ifdef ATTOPU_FETCH_PERF_EN
    logic [31:0] perf_instr_q, perf_wait_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_instr_q <= '0;
            perf_wait_q  <= '0;
        end else begin
            if (consume) begin
                perf_instr_q <= perf_instr_q + 32'd1;
            end
            if ((state_q == FS_FETCH) && !imem_ack) begin
                perf_wait_q <= perf_wait_q + 32'd1;
            end
        end
    end

    assign perf_instr_cnt = perf_instr_q;
    assign perf_wait_cnt  = perf_wait_q;
`endif

endmodule
